bias_pingpong_buffer: RTL
=========================

Name: bias_pingpong_buffer

Overview:
- Double-banked (ping-pong) bias store for the NPU core, parametrised in data width and depth.
- The host (AXI BRAM controller) fills the idle "fill" bank while the core reads the "active" bank.
- A swap handshake at layer boundaries exchanges the banks. Bias preload therefore overlaps compute, with no host/core address muxing or write loss.

Parameters:
- DATA_W, 512, word width in bits; must be a multiple of 8.
- ADDR_W, 7, address width; depth per bank = 2^ADDR_W.
- REG_OUT, 1, 1 adds an output register stage on both read paths; 0 drives data straight from RAM.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_host_en  in  1  host access request (to fill bank)
- i_host_we  in  1  1 = write, 0 = read
- i_host_be  in  DATA_W/8  byte enables for writes
- i_host_addr  in  ADDR_W  host word address
- i_host_wdata  in  DATA_W  host write data
- o_host_rdy  out  1  host access accepted this cycle when high
- o_host_rdata  out  DATA_W  host read data
- o_host_rvld  out  1  host read data valid
- i_host_done  in  1  pulse: fill bank fully loaded
- i_core_rd_en  in  1  core read request (active bank)
- i_core_addr  in  ADDR_W  core word address
- o_core_dat  out  DATA_W  core read data
- o_core_dat_vld  out  1  core read data valid
- i_swap_req  in  1  pulse: request bank swap
- o_swap_ack  out  1  one-cycle pulse: swap done
- o_fill_ready  out  1  fill bank marked loaded
- o_active_bank  out  1  index of bank currently read by core

Behaviour:
- Clock i_clk; reset i_rst_n, asynchronous, active-low.
- Reset values:
  - o_active_bank=0, o_fill_ready=0, state=IDLE.
  - o_swap_ack=0, o_host_rvld=0, o_core_dat_vld=0.
  - o_host_rdata=0 and o_core_dat=0 when REG_OUT=1.
  - o_host_rdy=1.
  - RAM contents are not reset.
- Storage:
  - Two single-port synchronous RAMs, bank0 and bank1, each 2^ADDR_W x DATA_W with byte-write enable.
  - Host always addresses bank ~active; the core always addresses bank active.
  - The two sides never share a RAM port, so there is no arbitration between them.
- Host write: accepted when i_host_en & i_host_we & o_host_rdy. Only bytes with be[i]=1 are written.
- Host read: accepted when i_host_en & ~i_host_we & o_host_rdy. o_host_rvld and data follow 1+REG_OUT cycles later.
- Core read: i_core_rd_en -> o_core_dat_vld and data 1+REG_OUT cycles later; back-to-back reads give back-to-back valids.
- Data-out hold: when no read returns, o_core_dat and o_host_rdata hold their last value.
- Bank latching: the bank select is latched per request at acceptance. Data in flight across a swap returns from the bank it was issued to.
- o_fill_ready:
  - Set on an i_host_done pulse.
  - Cleared in the SWAP cycle.
  - Host writes while set are still accepted and overwrite data.
- FSM:
  - IDLE: i_swap_req -> PENDING.
  - PENDING: waits for all of the following, then -> SWAP:
    - o_fill_ready=1, or i_host_done in the same cycle (seen next cycle);
    - i_core_rd_en=0 this cycle;
    - no core read in flight (last 1+REG_OUT cycles idle).
    - Core reads in PENDING are served from the old active bank.
  - SWAP (1 cycle): o_active_bank toggles, o_fill_ready cleared, o_host_rdy=0 (host access stalled) -> ACK.
  - ACK (1 cycle): o_swap_ack=1 -> IDLE.
  - o_host_rdy=1 in all other states.
- Boundary cases:
  - i_swap_req while not IDLE: ignored, no queuing.
  - i_host_done while ready: no effect.
  - i_host_done in the SWAP cycle: applies to the new fill bank (ready=1 after SWAP).
  - Address wrap: addresses are modulo 2^ADDR_W, no error flag.
  - Reset mid-swap: returns to IDLE, bank 0 active, ready cleared, in-flight valids dropped.

Test Plan:
1. Reset, then host writes 0xA5.. pattern to addr 0..127 of fill bank (bank1), i_host_done, i_swap_req -> o_swap_ack 3 cycles after req, o_active_bank=1. Core reads addr 5 -> o_core_dat equals written word at 2 cycles (REG_OUT=1).
2. Byte-enable write be=0x...0001 of 0xFF.. over word 0x00.. at addr 3, host read addr 3 -> o_host_rvld after 2 cycles, rdata=0x..00FF.
3. i_swap_req with o_fill_ready=0, hold 10 cycles, then i_host_done -> swap occurs after done, not before; o_host_rdy low exactly one cycle.
4. Continuous core reads during PENDING for 6 cycles -> no swap until reads stop and pipeline drains; all 6 reads return old-bank data.
5. Host read issued the cycle before SWAP -> rdata comes from pre-swap fill bank; core read issued the cycle after ACK reads new active bank.
6. Assert i_rst_n=0 in SWAP state -> all outputs at reset values, o_active_bank=0. Repeat scenario 1 with REG_OUT=0 -> 1-cycle latency.

Source files
------------

// File: rtl/bias_pingpong_buffer_if.sv
// Host fill bus, core read bus and swap handshake
// of the ping-pong bias store.
interface bias_pingpong_buffer_if #(
  parameter int DATA_W = 512,
  parameter int ADDR_W = 7
);
  logic                i_host_en;
  logic                i_host_we;
  logic [DATA_W/8-1:0] i_host_be;
  logic [ADDR_W-1:0]   i_host_addr;
  logic [DATA_W-1:0]   i_host_wdata;
  logic                o_host_rdy;
  logic [DATA_W-1:0]   o_host_rdata;
  logic                o_host_rvld;
  logic                i_host_done;
  logic                i_core_rd_en;
  logic [ADDR_W-1:0]   i_core_addr;
  logic [DATA_W-1:0]   o_core_dat;
  logic                o_core_dat_vld;
  logic                i_swap_req;
  logic                o_swap_ack;
  logic                o_fill_ready;
  logic                o_active_bank;

  modport slave (
    input  i_host_en, i_host_we, i_host_be,
    input  i_host_addr, i_host_wdata, i_host_done,
    input  i_core_rd_en, i_core_addr, i_swap_req,
    output o_host_rdy, o_host_rdata, o_host_rvld,
    output o_core_dat, o_core_dat_vld,
    output o_swap_ack, o_fill_ready, o_active_bank
  );

  modport master (
    output i_host_en, i_host_we, i_host_be,
    output i_host_addr, i_host_wdata, i_host_done,
    output i_core_rd_en, i_core_addr, i_swap_req,
    input  o_host_rdy, o_host_rdata, o_host_rvld,
    input  o_core_dat, o_core_dat_vld,
    input  o_swap_ack, o_fill_ready, o_active_bank
  );
endinterface

// File: rtl/bias_pingpong_buffer.sv
// Double-banked bias store: host fills one bank while
// the core reads the other; a handshake swaps them.
module bias_pingpong_buffer #(
  parameter int DATA_W  = 512,
  parameter int ADDR_W  = 7,
  parameter bit REG_OUT = 1'b1
) (
  input logic i_clk,
  input logic i_rst_n,
  bias_pingpong_buffer_if.slave bus
);
  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE, PENDING, SWAP, ACK
  } state_e;

  state_e state_q, state_d;
  logic   active_q, active_d;
  logic   fill_rdy_q, fill_rdy_d;

  logic host_rdy;
  logic host_wr;
  logic host_rd;
  logic host_bank;
  logic core_busy;

  logic [DATA_W-1:0] mem0 [DEPTH];
  logic [DATA_W-1:0] mem1 [DEPTH];

  logic [DATA_W-1:0] hraw_q;
  logic [DATA_W-1:0] craw_q;
  logic              hv1_q;
  logic              cv1_q;

  assign host_rdy  = (state_q != SWAP);
  assign host_bank = ~active_q;
  assign host_wr   = bus.i_host_en & bus.i_host_we & host_rdy;
  assign host_rd   = bus.i_host_en & ~bus.i_host_we & host_rdy;

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < NB; i++) begin
      if (host_wr && !host_bank && bus.i_host_be[i])
        mem0[bus.i_host_addr][8*i +: 8] <= bus.i_host_wdata[8*i +: 8];
      if (host_wr && host_bank && bus.i_host_be[i])
        mem1[bus.i_host_addr][8*i +: 8] <= bus.i_host_wdata[8*i +: 8];
    end
  end

  // Bank is chosen at acceptance, so a swap never redirects in-flight data
  always_ff @(posedge i_clk) begin
    if (host_rd)
      hraw_q <= host_bank ? mem1[bus.i_host_addr]
                          : mem0[bus.i_host_addr];
    if (bus.i_core_rd_en)
      craw_q <= active_q ? mem1[bus.i_core_addr]
                         : mem0[bus.i_core_addr];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hv1_q <= 1'b0;
      cv1_q <= 1'b0;
    end else begin
      hv1_q <= host_rd;
      cv1_q <= bus.i_core_rd_en;
    end
  end

  if (REG_OUT) begin : g_reg
    logic [DATA_W-1:0] hdat_q;
    logic [DATA_W-1:0] cdat_q;
    logic              hv2_q;
    logic              cv2_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        hdat_q <= '0;
        cdat_q <= '0;
        hv2_q  <= 1'b0;
        cv2_q  <= 1'b0;
      end else begin
        hv2_q <= hv1_q;
        cv2_q <= cv1_q;
        if (hv1_q) hdat_q <= hraw_q;
        if (cv1_q) cdat_q <= craw_q;
      end
    end

    assign bus.o_host_rdata   = hdat_q;
    assign bus.o_host_rvld    = hv2_q;
    assign bus.o_core_dat     = cdat_q;
    assign bus.o_core_dat_vld = cv2_q;
    assign core_busy          = cv1_q | cv2_q;
  end else begin : g_raw
    assign bus.o_host_rdata   = hraw_q;
    assign bus.o_host_rvld    = hv1_q;
    assign bus.o_core_dat     = craw_q;
    assign bus.o_core_dat_vld = cv1_q;
    assign core_busy          = cv1_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      active_q   <= 1'b0;
      fill_rdy_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      active_q   <= active_d;
      fill_rdy_q <= fill_rdy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    active_d   = active_q;
    fill_rdy_d = fill_rdy_q;
    if (bus.i_host_done) fill_rdy_d = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (bus.i_swap_req) state_d = PENDING;
      end
      PENDING: begin
        if (fill_rdy_q && !bus.i_core_rd_en && !core_busy)
          state_d = SWAP;
      end
      SWAP: begin
        active_d   = ~active_q;
        // a done arriving now belongs to the new fill bank
        fill_rdy_d = bus.i_host_done;
        state_d    = ACK;
      end
      ACK: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.o_host_rdy    = host_rdy;
  assign bus.o_swap_ack    = (state_q == ACK);
  assign bus.o_fill_ready  = fill_rdy_q;
  assign bus.o_active_bank = active_q;

endmodule
